fetcher: RTL and testbench

Instruction fetch unit and instruction queue: holds the fetch PC and issues one outstanding instruction request at a time to the icache. It pre-decodes JAL for next-PC prediction and buffers fetched instructions with their PC and predicted PC. It supplies them in order to the issue stage's decoder. It sits between the icache/memory controller and issue; a rollback from the ROB flushes it and redirects the PC.

---
 rtl/fetcher_pkg.sv | 30 +++
 rtl/fetcher_if.sv | 39 +++
 rtl/fetch_predictor.sv | 21 ++
 rtl/fetcher.sv | 141 ++++++++++++++
 tb/tb_fetcher.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetcher_pkg.sv
// Shared constants, types and decode helpers for the instruction fetch unit.
package fetcher_pkg;

   localparam int IQ_DEPTH_DEF = 16;
   localparam int ADDR_W_DEF   = 32;
   localparam int INST_W       = 32;

   localparam logic       TRUE         = 1'b1;
   localparam logic       FALSE        = 1'b0;
   localparam int         OPCODE_RANGE = 7;
   localparam logic [6:0] OPCODE_JAL   = 7'b1101111;

   typedef logic [INST_W-1:0] inst_t;

   typedef enum logic [1:0] {
      FETCH_IDLE    = 2'd0,
      FETCH_WAIT    = 2'd1,
      FETCH_DISCARD = 2'd2
   } fetch_state_e;

   function automatic logic is_jal(input inst_t inst);
      return inst[OPCODE_RANGE-1:0] == OPCODE_JAL;
   endfunction

   // J-type immediate, bit 0 implied zero; caller sign-extends from bit 20.
   function automatic logic [20:0] jal_imm(input inst_t inst);
      return {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
   endfunction

endpackage

// File: rtl/fetcher_if.sv
// Icache, issue and rollback signals of the fetch unit, bundled with the
// global enable; master is the fetch unit, slave is its environment.
interface fetcher_if #(
   parameter int ADDR_W = 32
);
   import fetcher_pkg::*;

   logic              rdy;
   logic              ic_req_valid;
   logic [ADDR_W-1:0] ic_req_addr;
   logic              ic_resp_valid;
   inst_t             ic_resp_inst;
   logic              out_valid;
   inst_t             out_inst;
   logic [ADDR_W-1:0] out_pc;
   logic [ADDR_W-1:0] out_pred_pc;
   logic              issue_ready;
   logic              rollback_en;
   logic [ADDR_W-1:0] rollback_pc;

   modport master (
      input  rdy,
      output ic_req_valid, ic_req_addr,
      input  ic_resp_valid, ic_resp_inst,
      output out_valid, out_inst, out_pc, out_pred_pc,
      input  issue_ready,
      input  rollback_en, rollback_pc
   );

   modport slave (
      output rdy,
      input  ic_req_valid, ic_req_addr,
      output ic_resp_valid, ic_resp_inst,
      input  out_valid, out_inst, out_pc, out_pred_pc,
      output issue_ready,
      output rollback_en, rollback_pc
   );

endinterface

// File: rtl/fetch_predictor.sv
// Static next-PC predictor: JAL is taken, everything else falls through.
// Kept as its own block so a BTB can take its place.
module fetch_predictor
   import fetcher_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic [ADDR_W-1:0] pc,
   input  inst_t             inst,
   output logic [ADDR_W-1:0] pred_pc
);

   logic [ADDR_W-1:0] offset;

   // NOTE: combinational logic uses blocking assignments and covers every path.
   always_comb begin
      offset  = is_jal(inst) ? ADDR_W'($signed(jal_imm(inst))) : ADDR_W'(4);
      pred_pc = pc + offset;
   end

endmodule

// File: rtl/fetcher.sv
// Instruction fetch unit: one outstanding icache request at a time, JAL
// pre-decode for the next PC, and an in-order instruction queue toward issue.
module fetcher
   import fetcher_pkg::*;
#(
   parameter int IQ_DEPTH = IQ_DEPTH_DEF,
   parameter int ADDR_W   = ADDR_W_DEF
) (
   input logic       clk,
   input logic       rst,
   fetcher_if.master bus
);

   localparam int              PTR_W      = $clog2(IQ_DEPTH);
   localparam logic [PTR_W:0]  FULL_COUNT = (PTR_W+1)'(IQ_DEPTH);

   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [PTR_W-1:0]  ptr_t;
   typedef logic [PTR_W:0]    cnt_t;

   fetch_state_e state_q, state_d;
   addr_t        fetch_pc_q, fetch_pc_d;
   addr_t        req_addr_q, req_addr_d;
   logic         req_valid_q, req_valid_d;
   ptr_t         head_q, head_d;
   ptr_t         tail_q, tail_d;
   cnt_t         count_q, count_d;
   logic         push, pop;
   addr_t        pred_pc;

   inst_t inst_mem [IQ_DEPTH];
   addr_t pc_mem   [IQ_DEPTH];
   addr_t pred_mem [IQ_DEPTH];

   fetch_predictor #(.ADDR_W(ADDR_W)) u_predictor (
      .pc      (fetch_pc_q),
      .inst    (bus.ic_resp_inst),
      .pred_pc (pred_pc)
   );

   // Request pulse is masked while frozen; the icache is frozen by the same rdy.
   assign bus.ic_req_valid = req_valid_q & bus.rdy;
   assign bus.ic_req_addr  = req_addr_q;

   assign bus.out_valid   = (count_q != '0);
   assign bus.out_inst    = inst_mem[head_q];
   assign bus.out_pc      = pc_mem[head_q];
   assign bus.out_pred_pc = pred_mem[head_q];

   always_comb begin
      // NOTE: every output gets a default first so no path infers a latch.
      state_d     = state_q;
      fetch_pc_d  = fetch_pc_q;
      req_valid_d = 1'b0;
      req_addr_d  = req_addr_q;
      head_d      = head_q;
      tail_d      = tail_q;
      count_d     = count_q;
      push        = 1'b0;
      pop         = 1'b0;

      if (bus.rollback_en) begin
         head_d     = '0;
         tail_d     = '0;
         count_d    = '0;
         fetch_pc_d = bus.rollback_pc;
         // An in-flight request must still be drained, so WAIT becomes DISCARD.
         unique case (state_q)
            FETCH_WAIT,
            FETCH_DISCARD: state_d = bus.ic_resp_valid ? FETCH_IDLE : FETCH_DISCARD;
            default:       state_d = FETCH_IDLE;
         endcase
      end else begin
         pop = (count_q != '0) && bus.issue_ready;

         unique case (state_q)
            FETCH_IDLE: begin
               if (count_q < FULL_COUNT) begin
                  req_valid_d = 1'b1;
                  req_addr_d  = fetch_pc_q;
                  state_d     = FETCH_WAIT;
               end
            end
            FETCH_WAIT: begin
               if (bus.ic_resp_valid) begin
                  push       = 1'b1;
                  fetch_pc_d = pred_pc;
                  state_d    = FETCH_IDLE;
               end
            end
            FETCH_DISCARD: begin
               if (bus.ic_resp_valid) begin
                  state_d = FETCH_IDLE;
               end
            end
            default: state_d = FETCH_IDLE;
         endcase

         // A request is only made below full, so a push never meets a full queue.
         if (push) tail_d = tail_q + PTR_W'(1);
         if (pop)  head_d = head_q + PTR_W'(1);

         unique case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= FETCH_IDLE;
         fetch_pc_q  <= '0;
         req_valid_q <= 1'b0;
         req_addr_q  <= '0;
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
      end else if (bus.rdy) begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         req_valid_q <= req_valid_d;
         req_addr_q  <= req_addr_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
      end
   end

   // NOTE: queue storage is not reset; count_q decides which entries are live.
   always_ff @(posedge clk) begin
      if (!rst && bus.rdy && push) begin
         inst_mem[tail_q] <= bus.ic_resp_inst;
         pc_mem[tail_q]   <= fetch_pc_q;
         pred_mem[tail_q] <= pred_pc;
      end
   end

endmodule

// File: tb/tb_fetcher.sv
// Randomized scoreboard bench for fetcher: a behavioural icache and program
// image, a next-PC reference model, and a monitor on the queue head.
module tb_fetcher;
   import fetcher_pkg::*;

   localparam int DEPTH = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;

   fetcher_if #(.ADDR_W(32)) bus ();

   fetcher #(.IQ_DEPTH(DEPTH), .ADDR_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [31:0] pred;
   } exp_t;

   exp_t        exp_q[$];
   int          n_cmp     = 0;
   int          n_err     = 0;
   int          mem_mode  = 0;
   int          fixed_lat = 2;
   int          req_count = 0;
   logic [31:0] model_pc  = '0;
   bit          outstanding = 1'b0;
   bit          stale       = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s: expected event did not occur (t=%0t)", name, $time);
   endtask

   function automatic logic [31:0] enc_jal(input int off);
      logic [20:0] imm;
      imm = 21'(off);
      return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'h6F};
   endfunction

   // Program image: fixed words at the directed addresses, otherwise a hash.
   function automatic logic [31:0] mem_inst(input logic [31:0] a);
      logic [31:0] h;
      logic [6:0]  opc;
      case (a)
         32'h0000_0010: return 32'h0100006F;
         32'h0000_0020: return 32'hFF9FF06F;
         32'hFFFF_FFFC: return 32'h0080006F;
         default: ;
      endcase
      if (mem_mode == 0) return 32'h0000_0013;
      h = a * 32'h9E3779B1;
      h = h ^ (h >> 15);
      h = h * 32'h85EBCA6B;
      h = h ^ (h >> 13);
      if (h[2:0] == 3'd0) return enc_jal((int'(h[12:4]) - 256) * 4);
      case (h[5:3])
         3'd0: opc = 7'h13;
         3'd1: opc = 7'h63;
         3'd2: opc = 7'h67;
         3'd3: opc = 7'h33;
         3'd4: opc = 7'h6E;
         3'd5: opc = 7'h2F;
         3'd6: opc = 7'h03;
         default: opc = 7'h6D;
      endcase
      return {h[31:7], opc};
   endfunction

   // Next PC from the architectural rule: JAL jumps by its signed offset.
   function automatic logic [31:0] ref_pred(input logic [31:0] pc, input logic [31:0] inst);
      int off;
      if (inst[6:0] != 7'h6F) return pc + 32'd4;
      off = int'(inst[30:21]) * 2 + int'(inst[20]) * 2048 + int'(inst[19:12]) * 4096
            - (inst[31] ? 1048576 : 0);
      return pc + 32'(off);
   endfunction

   // Icache: latches one request, answers after 1..4 enabled cycles.
   initial begin : icache
      bit          pend;
      int          lat;
      logic [31:0] addr;
      pend = 1'b0;
      lat  = 0;
      addr = '0;
      bus.ic_resp_valid = 1'b0;
      bus.ic_resp_inst  = '0;
      forever begin
         @(posedge clk);
         #2;
         bus.ic_resp_valid = 1'b0;
         if (rst) begin
            pend = 1'b0;
         end else if (bus.rdy) begin
            if (pend) begin
               lat--;
               if (lat == 0) begin
                  bus.ic_resp_valid = 1'b1;
                  bus.ic_resp_inst  = mem_inst(addr);
                  pend = 1'b0;
               end
            end else if (bus.ic_req_valid) begin
               pend = 1'b1;
               addr = bus.ic_req_addr;
               lat  = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4));
            end
         end
      end
   end

   // Reference model: observes stimulus, pushes expected queue entries.
   initial begin : model
      logic [31:0] nxt;
      forever begin
         @(negedge clk);
         if (rst) begin
            exp_q.delete();
            model_pc    = '0;
            outstanding = 1'b0;
            stale       = 1'b0;
            continue;
         end
         check("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
         if (!bus.rdy) begin
            check("req_while_frozen", 32'(bus.ic_req_valid), 32'd0);
            continue;
         end
         if (bus.ic_req_valid) begin
            req_count++;
            check("req_addr", bus.ic_req_addr, model_pc);
            check("req_while_outstanding", 32'(outstanding), 32'd0);
            outstanding = 1'b1;
         end
         if (bus.ic_resp_valid) begin
            if (!stale && !bus.rollback_en) begin
               nxt = ref_pred(model_pc, bus.ic_resp_inst);
               exp_q.push_back('{inst: bus.ic_resp_inst, pc: model_pc, pred: nxt});
               model_pc = nxt;
            end
            outstanding = 1'b0;
            stale       = 1'b0;
         end
         if (bus.rollback_en) begin
            exp_q.delete();
            model_pc = bus.rollback_pc;
            stale    = outstanding;
         end
      end
   end

   // Monitor: compares the presented head and retires it on a handshake.
   initial begin : monitor
      forever begin
         @(negedge clk);
         #1;
         if (rst || (bus.rollback_en && bus.rdy) || !bus.out_valid) continue;
         if (exp_q.size() == 0) begin
            fail_now("head_without_expected_entry");
         end else begin
            check("head_inst", bus.out_inst, exp_q[0].inst);
            check("head_pc", bus.out_pc, exp_q[0].pc);
            check("head_pred_pc", bus.out_pred_pc, exp_q[0].pred);
            if (bus.rdy && bus.issue_ready) void'(exp_q.pop_front());
         end
      end
   end

   task automatic pulse_rollback(input logic [31:0] pc);
      @(posedge clk);
      #1;
      bus.rollback_en = 1'b1;
      bus.rollback_pc = pc;
      @(posedge clk);
      #1;
      bus.rollback_en = 1'b0;
   endtask

   initial begin : driver
      int base;
      bit hit;
      bus.rdy         = 1'b1;
      bus.issue_ready = 1'b1;
      bus.rollback_en = 1'b0;
      bus.rollback_pc = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_req_valid", 32'(bus.ic_req_valid), 32'd0);
      check("rst_req_addr", bus.ic_req_addr, 32'd0);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("req_before_first", 32'(bus.ic_req_valid), 32'd0);
      @(negedge clk);
      check("first_req_valid", 32'(bus.ic_req_valid), 32'd1);
      check("first_req_addr", bus.ic_req_addr, 32'd0);

      // Sequential NOPs, then the two JALs at 0x10 and 0x20.
      repeat (60) @(posedge clk);

      // JAL at the top of the address space wraps forward.
      pulse_rollback(32'hFFFF_FFFC);
      repeat (40) @(posedge clk);

      // Rollback while a request is in flight: its response must be dropped.
      fixed_lat = 3;
      repeat (10) @(posedge clk);
      hit = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk);
         #1;
         if (outstanding && !stale) begin
            hit = 1'b1;
            break;
         end
      end
      if (!hit) fail_now("rollback_wait_window");
      bus.rollback_en = 1'b1;
      bus.rollback_pc = 32'h0000_0200;
      @(posedge clk);
      #1 bus.rollback_en = 1'b0;
      @(negedge clk);
      check("out_valid_after_rollback", 32'(bus.out_valid), 32'd0);
      hit = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.ic_req_valid) begin
            check("redirect_req_addr", bus.ic_req_addr, 32'h0000_0200);
            hit = 1'b1;
            break;
         end
      end
      if (!hit) fail_now("redirect_req_timeout");

      // Rollback coinciding with a response and a pop.
      mem_mode        = 1;
      fixed_lat       = 0;
      bus.issue_ready = 1'b0;
      repeat (20) @(posedge clk);
      hit = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         #3;
         if (bus.ic_resp_valid && bus.out_valid) begin
            bus.issue_ready = 1'b1;
            bus.rollback_en = 1'b1;
            bus.rollback_pc = 32'h0000_0300;
            hit = 1'b1;
            break;
         end
      end
      if (!hit) fail_now("coincide_window");
      @(posedge clk);
      #1;
      bus.rollback_en = 1'b0;
      bus.issue_ready = 1'b0;
      @(negedge clk);
      check("out_valid_after_coincide", 32'(bus.out_valid), 32'd0);

      // Fill the queue: no requests while full, exactly one after a single pop.
      hit = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk);
         #1;
         if (exp_q.size() == DEPTH) begin
            hit = 1'b1;
            break;
         end
      end
      if (!hit) fail_now("fill_timeout");
      repeat (2) @(posedge clk);
      base = req_count;
      repeat (20) @(posedge clk);
      check("req_while_full", 32'(req_count - base), 32'd0);
      #1;
      bus.issue_ready = 1'b1;
      base = req_count;
      @(posedge clk);
      #1 bus.issue_ready = 1'b0;
      repeat (20) @(posedge clk);
      check("req_after_one_pop", 32'(req_count - base), 32'd1);

      // Freeze mid-stream for five cycles.
      #1 bus.issue_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1 bus.rdy = 1'b0;
      repeat (5) @(posedge clk);
      #1 bus.rdy = 1'b1;
      repeat (10) @(posedge clk);

      // Random traffic: back-pressure, freezes and redirects.
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk);
         #1;
         bus.rdy         = ($urandom_range(0, 9) != 0);
         bus.issue_ready = ($urandom_range(0, 3) != 0);
         bus.rollback_en = bus.rdy && ($urandom_range(0, 49) == 0);
         case ($urandom_range(0, 3))
            0:       bus.rollback_pc = 32'h0000_0010;
            1:       bus.rollback_pc = 32'hFFFF_FFFC;
            default: bus.rollback_pc = $urandom() & 32'h0000_FFFC;
         endcase
      end

      @(posedge clk);
      #1;
      bus.rdy         = 1'b1;
      bus.issue_ready = 1'b1;
      bus.rollback_en = 1'b0;
      repeat (60) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
